// File: rtl/lcd_ctrl_if.sv
// Command/data request channel into the LCD driver.
// Request is taken on an edge where req_valid and req_ready are both high.
interface lcd_ctrl_if;
    logic       req_valid;
    logic       req_rs;
    logic [7:0] req_data;
    logic       req_ready;

    modport master (output req_valid, req_rs, req_data, input  req_ready);
    modport slave  (input  req_valid, req_rs, req_data, output req_ready);
endinterface

// File: rtl/lcd_ctrl.sv
// HD44780 driver: runs power-up init, then sends one byte per request with full bus timing.
// Latency: ready returns T_SETUP+T_EN+T_HOLD+(T_CLEAR or T_EXEC) cycles after the accepting edge.
// Backpressure: ready only in IDLE after init; valid while not ready is ignored, not queued.
module lcd_ctrl #(
    parameter int T_PWRUP = 750000,
    parameter int T_SETUP = 2,
    parameter int T_EN    = 12,
    parameter int T_HOLD  = 2,
    parameter int T_EXEC  = 2000,
    parameter int T_CLEAR = 82000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    lcd_ctrl_if.slave   req,
    output logic        o_init_done,
    output logic [31:0] o_io_lcd
);

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = max_of(max_of(max_of(T_PWRUP, T_SETUP), max_of(T_EN, T_HOLD)),
                                  max_of(T_EXEC, T_CLEAR));
    localparam int CW = $clog2(T_MAX + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // The init-ROM load has no cycle of its own: it happens on the transition into SETUP.
    typedef enum logic [2:0] {PWRUP, SETUP, EN_HI, HOLD, EXEC, IDLE} state_t;

    function automatic logic [7:0] init_rom(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rs_q, rs_d;
    logic [7:0]      data_q, data_d;
    logic [2:0]      idx_q, idx_d;
    logic            init_done_q, init_done_d;
    logic            en_q;
    logic            on_q;
    logic            load_init;
    logic            last;
    logic            is_clear;

    // Clear display / return home need the long execution wait.
    assign is_clear = !rs_q && (data_q[7:2] == 6'd0) && (data_q != 8'd0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rs_d        = rs_q;
        data_d      = data_q;
        idx_d       = idx_q;
        init_done_d = init_done_q;
        load_init   = 1'b0;
        last        = (cnt_q == CNT_ONE);
        case (state_q)
            PWRUP: begin
                if (last) load_init = 1'b1;
                else      cnt_d     = cnt_q - CNT_ONE;
            end
            SETUP: begin
                if (last) begin
                    state_d = EN_HI;
                    cnt_d   = CW'(T_EN);
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            EN_HI: begin
                if (last) begin
                    state_d = HOLD;
                    cnt_d   = CW'(T_HOLD);
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            HOLD: begin
                if (last) begin
                    state_d = EXEC;
                    cnt_d   = is_clear ? CW'(T_CLEAR) : CW'(T_EXEC);
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            EXEC: begin
                if (last) begin
                    if (idx_q != 3'd4) begin
                        load_init = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        init_done_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            IDLE: begin
                if (req.req_valid) begin
                    rs_d    = req.req_rs;
                    data_d  = req.req_data;
                    state_d = SETUP;
                    cnt_d   = CW'(T_SETUP);
                end
            end
            default: begin
                state_d = PWRUP;
                cnt_d   = CW'(T_PWRUP);
            end
        endcase
        if (load_init) begin
            rs_d    = 1'b0;
            data_d  = init_rom(idx_q[1:0]);
            idx_d   = idx_q + 3'd1;
            state_d = SETUP;
            cnt_d   = CW'(T_SETUP);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= PWRUP;
            cnt_q       <= CW'(T_PWRUP);
            rs_q        <= 1'b0;
            data_q      <= 8'd0;
            idx_q       <= 3'd0;
            init_done_q <= 1'b0;
            en_q        <= 1'b0;
            on_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
            en_q        <= (state_d == EN_HI);
            on_q        <= 1'b1;
        end
    end

    assign req.req_ready = (state_q == IDLE);
    assign o_init_done   = init_done_q;
    assign o_io_lcd      = {on_q, 20'd0, rs_q, 1'b0, en_q, data_q};

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboarded bench for lcd_ctrl: expected bytes queued at acceptance, popped on each EN rise.
module tb_lcd_ctrl;
    localparam int T_PWRUP = 10;
    localparam int T_SETUP = 1;
    localparam int T_EN    = 2;
    localparam int T_HOLD  = 1;
    localparam int T_EXEC  = 4;
    localparam int T_CLEAR = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_done;
    logic [31:0] lcd;

    lcd_ctrl_if bus();

    lcd_ctrl #(
        .T_PWRUP(T_PWRUP), .T_SETUP(T_SETUP), .T_EN(T_EN),
        .T_HOLD(T_HOLD), .T_EXEC(T_EXEC), .T_CLEAR(T_CLEAR)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .req         (bus.slave),
        .o_init_done (init_done),
        .o_io_lcd    (lcd)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] sb[$];
    logic       rst_at_edge = 1'b1;
    int         edges = 0;

    always @(posedge clk) begin
        rst_at_edge <= rst;
        edges       <= edges + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference timing: whole-byte cost from the LCD command rules.
    function automatic int byte_latency(input logic rs, input logic [7:0] d);
        bit clear_home;
        clear_home = (rs == 1'b0) && (d == 8'h01 || d == 8'h02 || d == 8'h03);
        return T_SETUP + T_EN + T_HOLD + (clear_home ? T_CLEAR : T_EXEC);
    endfunction

    function automatic logic [7:0] rand_byte();
        if ($urandom_range(0, 3) == 0) return 8'($urandom_range(0, 3));
        return 8'($urandom);
    endfunction

    // Monitor: pin-word sanity every cycle, byte identity and pulse shape on EN.
    logic       en_prev = 1'b0;
    int         width = 0;
    int         stable = 0;
    logic [8:0] prev_word = 9'd0;

    always @(negedge clk) begin : mon
        logic [8:0] w;
        logic [8:0] exp_w;
        if (edges > 0) begin
            w = {lcd[10], lcd[7:0]};
            if (rst_at_edge) begin
                check("reset_lcd", lcd, 32'h0);
                en_prev   = 1'b0;
                width     = 0;
                stable    = 0;
                prev_word = 9'd0;
            end else begin
                check("lcd_fixed_bits", lcd & 32'hFFFF_FA00, 32'h8000_0000);
                if (lcd[8] && !en_prev) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_en: got byte %h expected no pulse", w);
                    end else begin
                        exp_w = sb.pop_front();
                        check("en_byte", 32'(w), 32'(exp_w));
                    end
                    check("setup_cycles", 32'(stable >= T_SETUP), 32'd1);
                    width = 1;
                end else if (lcd[8]) begin
                    check("en_data_stable", 32'(w), 32'(prev_word));
                    width++;
                end else begin
                    if (en_prev) check("en_width", 32'(width), 32'(T_EN));
                    if (w == prev_word) stable++;
                    else                stable = 1;
                end
                en_prev   = lcd[8];
                prev_word = w;
            end
        end
    end

    task automatic do_init(input string tag);
        logic [7:0] rom[4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
        int first_en = -1;
        int n = 0;
        int exp_n;
        int rel;
        bit early = 1'b0;
        exp_n = T_PWRUP;
        foreach (rom[i]) begin
            sb.push_back({1'b0, rom[i]});
            exp_n += byte_latency(1'b0, rom[i]);
        end
        rel = edges;
        rst = 1'b0;
        for (int g = 0; g < 300; g++) begin
            @(negedge clk);
            n = edges - rel;
            if (lcd[8] && first_en < 0) first_en = n;
            if (init_done && !bus.req_ready) early = 1'b1;
            if (bus.req_ready) break;
        end
        check({tag, "_ready_latency"}, 32'(n), 32'(exp_n));
        check({tag, "_first_en"}, 32'(first_en), 32'(T_PWRUP + T_SETUP));
        check({tag, "_init_done"}, 32'(init_done), 32'd1);
        check({tag, "_init_done_early"}, 32'(early), 32'd0);
        check({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic send_one(input logic rs, input logic [7:0] d);
        int n = 0;
        int acc;
        int lat;
        logic en_exp;
        lat = byte_latency(rs, d);
        bus.req_valid = 1'b1;
        bus.req_rs    = rs;
        bus.req_data  = d;
        for (int g = 0; g < 200 && !bus.req_ready; g++) @(negedge clk);
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready 0 expected 1");
            bus.req_valid = 1'b0;
            return;
        end
        acc = edges + 1;
        sb.push_back({rs, d});
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_rs    = 1'($urandom);
        bus.req_data  = 8'($urandom);
        for (int g = 0; g < 200; g++) begin
            n = edges - acc;
            en_exp = (n >= T_SETUP) && (n < T_SETUP + T_EN);
            if (n <= lat) check("lcd_word", lcd, {1'b1, 20'd0, rs, 1'b0, en_exp, d});
            if (bus.req_ready) break;
            @(negedge clk);
        end
        check("latency", 32'(n), 32'(lat));
    endtask

    // valid never drops; a new random byte every cycle, so only ready-cycle bytes may be sent.
    task automatic stream(input int count);
        int acc_n = 0;
        int acc_edge = 0;
        int lat = 0;
        bit pending = 1'b0;
        logic rs;
        logic [7:0] d;
        bus.req_valid = 1'b1;
        for (int g = 0; g < 5000 && acc_n < count; g++) begin
            rs = 1'($urandom);
            d  = rand_byte();
            bus.req_rs   = rs;
            bus.req_data = d;
            if (bus.req_ready) begin
                if (pending) check("stream_latency", 32'(edges - acc_edge), 32'(lat));
                sb.push_back({rs, d});
                lat      = byte_latency(rs, d);
                acc_edge = edges + 1;
                pending  = 1'b1;
                acc_n++;
            end
            @(negedge clk);
        end
        for (int g = 0; g < 200 && !bus.req_ready; g++) begin
            bus.req_data = 8'($urandom);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        check("stream_last_latency", 32'(edges - acc_edge), 32'(lat));
        check("stream_count", 32'(acc_n), 32'(count));
    endtask

    initial begin : wdog
        #500000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin : drv
        bus.req_valid = 1'b0;
        bus.req_rs    = 1'b0;
        bus.req_data  = 8'd0;
        rst           = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_ready", 32'(bus.req_ready), 32'd0);
        check("reset_init_done", 32'(init_done), 32'd0);
        do_init("init1");

        send_one(1'b1, 8'h41);
        send_one(1'b0, 8'h01);
        send_one(1'b0, 8'h80);
        send_one(1'b0, 8'h04);
        send_one(1'b0, 8'h02);
        send_one(1'b0, 8'h03);
        send_one(1'b0, 8'h00);
        send_one(1'b1, 8'h01);

        for (int i = 0; i < 30; i++) begin
            send_one(1'($urandom), rand_byte());
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        stream(20);

        // Reset in the middle of an EN pulse must abandon the byte and rerun init.
        bus.req_valid = 1'b1;
        bus.req_rs    = 1'b1;
        bus.req_data  = 8'h5A;
        for (int g = 0; g < 200 && !bus.req_ready; g++) @(negedge clk);
        sb.push_back({1'b1, 8'h5A});
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int g = 0; g < 50 && !lcd[8]; g++) @(negedge clk);
        @(negedge clk);
        check("midrst_in_en", 32'(lcd[8]), 32'd1);
        check("midrst_sb_popped", 32'(sb.size()), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_lcd", lcd, 32'h0);
        check("midrst_ready", 32'(bus.req_ready), 32'd0);
        check("midrst_init_done", 32'(init_done), 32'd0);
        @(negedge clk);
        do_init("init2");

        send_one(1'b1, 8'h7E);
        repeat (5) @(negedge clk);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
